if_id_skid_reg: RTL and testbench



---
 rtl/if_id_skid_reg_pkg.sv | 16 +
 rtl/if_id_skid_reg_sat_counter.sv | 22 ++
 rtl/if_id_skid_reg.sv | 108 ++++++++++
 tb/tb_if_id_skid_reg.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_skid_reg_pkg.sv
// Shared IF/ID pipeline definitions: stage state encoding, bubble payload
// defaults and the payload bundle width helper.
package if_id_skid_reg_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  localparam logic [31:0] NOP_INST_DEF = 32'h00000013;
  localparam logic [31:0] NOP_PC_DEF   = 32'h00000000;

  function automatic int payload_w(input int pc_w, input int inst_w, input int side_w);
    return pc_w + inst_w + side_w;
  endfunction

endpackage

// File: rtl/if_id_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID stage register with valid/ready handshake and a 2-entry skid buffer,
// flush with NOP injection and a decode-starvation bubble counter.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter int                SIDE_W   = 8,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
  parameter logic [PC_W-1:0]   NOP_PC   = PC_W'(NOP_PC_DEF),
  parameter int                CNT_W    = 16
) (
  input  logic              clk_IFID,
  input  logic              rst_n_IFID,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [INST_W-1:0] inst_in,
  input  logic [SIDE_W-1:0] side_in,
  input  logic              flush,
  output logic              valid_out,
  input  logic              ready_ds,
  output logic [PC_W-1:0]   pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic [SIDE_W-1:0] side_out,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int PAYLOAD_W = payload_w(PC_W, INST_W, SIDE_W);
  localparam logic [PAYLOAD_W-1:0] NOP_PAYLOAD = {NOP_PC, NOP_INST, {SIDE_W{1'b0}}};

  logic [1:0]           state_q;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic [PAYLOAD_W-1:0] payload_in;
  logic                 in_fire;
  logic                 out_fire;

  assign payload_in = {pc_in, inst_in, side_in};

  // Handshake flags come straight from the state register so ready_in never
  // has a combinational path from ready_ds.
  assign valid_out = (state_q != ST_EMPTY);
  assign ready_in  = (state_q != ST_SKID);
  assign occupancy = state_q;
  assign in_fire   = valid_in & ready_in;
  assign out_fire  = valid_out & ready_ds;

  assign {pc_out, inst_out, side_out} = main_q;

  // Every path into EMPTY reloads main with the NOP bundle, so the head
  // register alone supplies the bubble payload.
  always_ff @(posedge clk_IFID or negedge rst_n_IFID) begin
    if (!rst_n_IFID) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_PAYLOAD;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_PAYLOAD;
      skid_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_q <= ST_FULL;
            main_q  <= payload_in;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_q <= payload_in;
          end else if (in_fire) begin
            state_q <= ST_SKID;
            skid_q  <= payload_in;
          end else if (out_fire) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_PAYLOAD;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_q <= ST_FULL;
            main_q  <= skid_q;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          main_q  <= NOP_PAYLOAD;
          skid_q  <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk   (clk_IFID),
    .rst_n (rst_n_IFID),
    .inc   (!valid_out && ready_ds && !flush),
    .clr   (cnt_clr),
    .cnt   (bubble_cnt)
  );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg built with CNT_W=4 so saturation is reachable.
module tb_if_id_skid_reg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int SIDE_W = 8;
  localparam int CNT_W  = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              clk_IFID = 1'b0;
  logic              rst_n_IFID;
  logic              valid_in;
  logic              ready_in;
  logic [PC_W-1:0]   pc_in;
  logic [INST_W-1:0] inst_in;
  logic [SIDE_W-1:0] side_in;
  logic              flush;
  logic              valid_out;
  logic              ready_ds;
  logic [PC_W-1:0]   pc_out;
  logic [INST_W-1:0] inst_out;
  logic [SIDE_W-1:0] side_out;
  logic [1:0]        occupancy;
  logic              cnt_clr;
  logic [CNT_W-1:0]  bubble_cnt;

  int num_compared   = 0;
  int num_mismatched = 0;

  if_id_skid_reg #(
    .PC_W(PC_W), .INST_W(INST_W), .SIDE_W(SIDE_W), .CNT_W(CNT_W)
  ) dut (
    .clk_IFID  (clk_IFID),
    .rst_n_IFID(rst_n_IFID),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .pc_in     (pc_in),
    .inst_in   (inst_in),
    .side_in   (side_in),
    .flush     (flush),
    .valid_out (valid_out),
    .ready_ds  (ready_ds),
    .pc_out    (pc_out),
    .inst_out  (inst_out),
    .side_out  (side_out),
    .occupancy (occupancy),
    .cnt_clr   (cnt_clr),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk_IFID = ~clk_IFID;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk_IFID);
    #1;
  endtask

  task automatic present(input logic [31:0] pc);
    valid_in = 1'b1;
    pc_in    = pc;
    inst_in  = 32'h1000_0000 | pc;
    side_in  = pc[7:0] ^ 8'hA5;
  endtask

  task automatic test_reset();
    rst_n_IFID = 1'b0;
    valid_in = 1'b0; pc_in = '0; inst_in = '0; side_in = '0;
    flush = 1'b0; ready_ds = 1'b1; cnt_clr = 1'b0;
    #23;
    num_compared++;
    if ({valid_out, ready_in, occupancy} !== 4'b0100) begin
      num_mismatched++;
      $display("[TB] FAIL reset_flags: got %b, want 0100", {valid_out, ready_in, occupancy});
    end
    num_compared++;
    if ({pc_out, inst_out, side_out, bubble_cnt} !== {32'h0, NOP, 8'h00, 4'd0}) begin
      num_mismatched++;
      $display("[TB] FAIL reset_payload: got pc=%h inst=%h side=%h cnt=%0d", pc_out, inst_out, side_out, bubble_cnt);
    end
    rst_n_IFID = 1'b1;
    repeat (5) tick();
    num_compared++;
    if ({valid_out, ready_in, pc_out, inst_out, bubble_cnt} !== {1'b0, 1'b1, 32'h0, NOP, 4'd5}) begin
      num_mismatched++;
      $display("[TB] FAIL idle_starve: got v=%b r=%b pc=%h inst=%h cnt=%0d, want v=0 r=1 pc=0 inst=%h cnt=5",
               valid_out, ready_in, pc_out, inst_out, bubble_cnt, NOP);
    end
  endtask

  task automatic test_back_to_back();
    // First edge still sees an empty stage with ready_ds=1, so the count goes 5 -> 6.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pc;
      pc = 32'(i * 4);
      present(pc);
      tick();
      num_compared++;
      if ({valid_out, occupancy, pc_out, inst_out, side_out} !==
          {1'b1, 2'd1, pc, 32'h1000_0000 | pc, pc[7:0] ^ 8'hA5}) begin
        num_mismatched++;
        $display("[TB] FAIL stream_%0d: got v=%b occ=%0d pc=%h inst=%h side=%h, want pc=%h",
                 i, valid_out, occupancy, pc_out, inst_out, side_out, pc);
      end
    end
    valid_in = 1'b0;
    tick();
    num_compared++;
    if ({valid_out, occupancy, inst_out, bubble_cnt} !== {1'b0, 2'd0, NOP, 4'd6}) begin
      num_mismatched++;
      $display("[TB] FAIL stream_drain: got v=%b occ=%0d inst=%h cnt=%0d, want 0 0 %h 6",
               valid_out, occupancy, inst_out, bubble_cnt, NOP);
    end
    ready_ds = 1'b0;
  endtask

  task automatic test_skid();
    present(32'h10);
    tick();
    present(32'h14);
    tick();
    valid_in = 1'b0;
    num_compared++;
    if ({occupancy, ready_in, valid_out, pc_out} !== {2'd2, 1'b0, 1'b1, 32'h10}) begin
      num_mismatched++;
      $display("[TB] FAIL skid_fill: got occ=%0d r=%b v=%b pc=%h, want 2 0 1 10", occupancy, ready_in, valid_out, pc_out);
    end
    tick();
    num_compared++;
    if ({occupancy, pc_out} !== {2'd2, 32'h10}) begin
      num_mismatched++;
      $display("[TB] FAIL skid_hold: got occ=%0d pc=%h, want 2 10", occupancy, pc_out);
    end
    ready_ds = 1'b1;
    tick();
    num_compared++;
    if ({occupancy, ready_in, pc_out, side_out} !== {2'd1, 1'b1, 32'h14, 8'h14 ^ 8'hA5}) begin
      num_mismatched++;
      $display("[TB] FAIL skid_pop1: got occ=%0d r=%b pc=%h side=%h, want 1 1 14 b1", occupancy, ready_in, pc_out, side_out);
    end
    tick();
    num_compared++;
    if ({valid_out, occupancy, bubble_cnt} !== {1'b0, 2'd0, 4'd6}) begin
      num_mismatched++;
      $display("[TB] FAIL skid_pop2: got v=%b occ=%0d cnt=%0d, want 0 0 6", valid_out, occupancy, bubble_cnt);
    end
    ready_ds = 1'b0;
  endtask

  task automatic test_flush();
    present(32'h20);
    tick();
    present(32'h24);
    tick();
    present(32'h28);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid_in = 1'b0;
    num_compared++;
    if ({valid_out, ready_in, occupancy, pc_out, inst_out, side_out} !== {1'b0, 1'b1, 2'd0, 32'h0, NOP, 8'h00}) begin
      num_mismatched++;
      $display("[TB] FAIL flush_skid: got v=%b r=%b occ=%0d pc=%h inst=%h side=%h",
               valid_out, ready_in, occupancy, pc_out, inst_out, side_out);
    end
    ready_ds = 1'b1;
    tick();
    num_compared++;
    if ({valid_out, pc_out, bubble_cnt} !== {1'b0, 32'h0, 4'd7}) begin
      num_mismatched++;
      $display("[TB] FAIL flush_after: got v=%b pc=%h cnt=%0d, want 0 0 7", valid_out, pc_out, bubble_cnt);
    end
    ready_ds = 1'b0;
    present(32'h30);
    tick();
    present(32'h34);
    flush = 1'b1;
    tick();
    valid_in = 1'b0;
    num_compared++;
    if ({valid_out, occupancy, pc_out} !== {1'b0, 2'd0, 32'h0}) begin
      num_mismatched++;
      $display("[TB] FAIL flush_full_infire: got v=%b occ=%0d pc=%h, want 0 0 0", valid_out, occupancy, pc_out);
    end
    ready_ds = 1'b1;
    tick();
    flush = 1'b0;
    num_compared++;
    if ({valid_out, bubble_cnt} !== {1'b0, 4'd7}) begin
      num_mismatched++;
      $display("[TB] FAIL flush_no_count: got v=%b cnt=%0d, want 0 7", valid_out, bubble_cnt);
    end
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    num_compared++;
    if (bubble_cnt !== 4'd0) begin
      num_mismatched++;
      $display("[TB] FAIL cnt_clear: got %0d, want 0", bubble_cnt);
    end
    repeat (19) tick();
    num_compared++;
    if (bubble_cnt !== 4'd15) begin
      num_mismatched++;
      $display("[TB] FAIL cnt_saturate: got %0d, want 15", bubble_cnt);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    num_compared++;
    if (bubble_cnt !== 4'd0) begin
      num_mismatched++;
      $display("[TB] FAIL cnt_clr_priority: got %0d, want 0", bubble_cnt);
    end
    tick();
    num_compared++;
    if (bubble_cnt !== 4'd1) begin
      num_mismatched++;
      $display("[TB] FAIL cnt_resume: got %0d, want 1", bubble_cnt);
    end
  endtask

  task automatic test_async_reset();
    present(32'h38);
    tick();
    valid_in = 1'b0;
    ready_ds = 1'b0;
    #1;
    rst_n_IFID = 1'b0;
    #1;
    num_compared++;
    if ({valid_out, ready_in, occupancy, pc_out, inst_out, side_out, bubble_cnt} !==
        {1'b0, 1'b1, 2'd0, 32'h0, NOP, 8'h00, 4'd0}) begin
      num_mismatched++;
      $display("[TB] FAIL async_reset: got v=%b r=%b occ=%0d pc=%h inst=%h side=%h cnt=%0d",
               valid_out, ready_in, occupancy, pc_out, inst_out, side_out, bubble_cnt);
    end
    #2;
    rst_n_IFID = 1'b1;
    present(32'h40);
    ready_ds = 1'b1;
    tick();
    valid_in = 1'b0;
    num_compared++;
    if ({valid_out, occupancy, pc_out, inst_out} !== {1'b1, 2'd1, 32'h40, 32'h1000_0040}) begin
      num_mismatched++;
      $display("[TB] FAIL reset_resume: got v=%b occ=%0d pc=%h inst=%h, want 1 1 40 10000040",
               valid_out, occupancy, pc_out, inst_out);
    end
    tick();
    num_compared++;
    if ({valid_out, occupancy} !== {1'b0, 2'd0}) begin
      num_mismatched++;
      $display("[TB] FAIL reset_resume_drain: got v=%b occ=%0d, want 0 0", valid_out, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_skid();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
